// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and buffered, extended load returns into the register file write port.
// Optional WB_FWD_EN adds a held copy of the last register write for read-after-write forwarding.
module wb_stage #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int LQ_DEPTH   = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  alu_valid_i,
   output logic                  alu_ready_o,
   input  logic [REG_ADDR_W-1:0] alu_rd_addr_i,
   input  logic [XLEN-1:0]       alu_data_i,
   input  logic                  ld_valid_i,
   output logic                  ld_ready_o,
   input  logic [REG_ADDR_W-1:0] ld_rd_addr_i,
   input  logic [2:0]            ld_funct3_i,
   input  logic [1:0]            ld_byte_off_i,
   input  logic [XLEN-1:0]       ld_data_i,
   output logic [REG_ADDR_W-1:0] rd_addr_o,
   output logic                  rd_write_en_o,
   output logic [XLEN-1:0]       rd_data_o,
   output logic                  retire_o,
   output logic                  ld_err_o,
   output logic                  busy_o
`ifdef WB_FWD_EN
   ,
   output logic                  fwd_valid_o,
   output logic [REG_ADDR_W-1:0] fwd_addr_o,
   output logic [XLEN-1:0]       fwd_data_o
`endif
);

   localparam int LQ_AW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

   logic [REG_ADDR_W-1:0] lq_rd   [LQ_DEPTH];
   logic [2:0]            lq_f3   [LQ_DEPTH];
   logic [1:0]            lq_off  [LQ_DEPTH];
   logic [XLEN-1:0]       lq_data [LQ_DEPTH];
   logic [LQ_AW-1:0]      wr_ptr, rd_ptr;
   logic [LQ_AW:0]        lq_count;
   logic                  lq_full, lq_empty, armed;
   logic                  push, pop, alu_fire;

   logic [REG_ADDR_W-1:0] head_rd;
   logic [2:0]            head_f3;
   logic [1:0]            head_off;
   logic [XLEN-1:0]       head_data;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [XLEN-1:0]       ld_ext;
   logic                  ld_illegal;

   logic                  wr_en_d, retire_d, err_d;
   logic [REG_ADDR_W-1:0] wr_addr_d;
   logic [XLEN-1:0]       wr_data_d;

   // Handshake: a transfer happens on a rising clk_i edge where valid and ready are both 1;
   // ready depends only on registered state, and sources hold their payload while valid && !ready.
   // armed stays low for the first edge after reset release so nothing is accepted or written there.
   assign lq_full     = (lq_count == (LQ_AW+1)'(LQ_DEPTH));
   assign lq_empty    = (lq_count == '0);
   assign alu_ready_o = armed && !lq_full;
   assign ld_ready_o  = armed && !lq_full;
   assign busy_o      = !lq_empty;
   assign alu_fire    = alu_valid_i && alu_ready_o;
   assign push        = ld_valid_i && ld_ready_o;
   assign pop         = armed && (lq_full || (!alu_valid_i && !lq_empty));

   assign head_rd   = lq_rd[rd_ptr];
   assign head_f3   = lq_f3[rd_ptr];
   assign head_off  = lq_off[rd_ptr];
   assign head_data = lq_data[rd_ptr];
   assign ld_byte   = head_data[{head_off, 3'b000} +: 8];
   assign ld_half   = head_off[1] ? head_data[31:16] : head_data[15:0];

   always_comb begin
      ld_ext     = '0;
      ld_illegal = 1'b0;
      case (head_f3)
         3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = XLEN'(ld_byte);
         3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b101:  ld_ext = XLEN'(ld_half);
         3'b010:  ld_ext = head_data;
         default: ld_illegal = 1'b1;
      endcase
   end

   // ALU wins unless the load queue is full; x0 destinations retire without a write.
   always_comb begin
      wr_en_d   = 1'b0;
      retire_d  = 1'b0;
      err_d     = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      if (alu_fire) begin
         retire_d = 1'b1;
         if (alu_rd_addr_i != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = alu_rd_addr_i;
            wr_data_d = alu_data_i;
         end
      end else if (pop) begin
         retire_d = 1'b1;
         err_d    = ld_illegal;
         if (head_rd != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = head_rd;
            wr_data_d = ld_ext;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         lq_rd[wr_ptr]   <= ld_rd_addr_i;
         lq_f3[wr_ptr]   <= ld_funct3_i;
         lq_off[wr_ptr]  <= ld_byte_off_i;
         lq_data[wr_ptr] <= ld_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         armed    <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         lq_count <= '0;
      end else begin
         armed <= 1'b1;
         if (push) wr_ptr <= wr_ptr + LQ_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + LQ_AW'(1);
         case ({push, pop})
            2'b10:   lq_count <= lq_count + (LQ_AW+1)'(1);
            2'b01:   lq_count <= lq_count - (LQ_AW+1)'(1);
            default: lq_count <= lq_count;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_write_en_o <= 1'b0;
         retire_o      <= 1'b0;
         ld_err_o      <= 1'b0;
         rd_addr_o     <= '0;
         rd_data_o     <= '0;
      end else begin
         rd_write_en_o <= wr_en_d;
         retire_o      <= retire_d;
         ld_err_o      <= err_d;
         rd_addr_o     <= wr_addr_d;
         rd_data_o     <= wr_data_d;
      end
   end

`ifdef WB_FWD_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fwd_valid_o <= 1'b0;
         fwd_addr_o  <= '0;
         fwd_data_o  <= '0;
      end else if (wr_en_d) begin
         fwd_valid_o <= 1'b1;
         fwd_addr_o  <= wr_addr_d;
         fwd_data_o  <= wr_data_d;
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU writes, load extension, arbitration under a full queue, x0, reset mid-operation.
module tb_wb_stage;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        alu_valid_i = 1'b0;
   logic        alu_ready_o;
   logic [4:0]  alu_rd_addr_i = '0;
   logic [31:0] alu_data_i = '0;
   logic        ld_valid_i = 1'b0;
   logic        ld_ready_o;
   logic [4:0]  ld_rd_addr_i = '0;
   logic [2:0]  ld_funct3_i = '0;
   logic [1:0]  ld_byte_off_i = '0;
   logic [31:0] ld_data_i = '0;
   logic [4:0]  rd_addr_o;
   logic        rd_write_en_o;
   logic [31:0] rd_data_o;
   logic        retire_o, ld_err_o, busy_o;
`ifdef WB_FWD_EN
   logic        fwd_valid_o;
   logic [4:0]  fwd_addr_o;
   logic [31:0] fwd_data_o;
`endif

   int total = 0;
   int bad = 0;

   localparam int W = 37;
   logic [W-1:0] exp_q[$];

   wb_stage dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
      .alu_rd_addr_i(alu_rd_addr_i), .alu_data_i(alu_data_i),
      .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
      .ld_rd_addr_i(ld_rd_addr_i), .ld_funct3_i(ld_funct3_i),
      .ld_byte_off_i(ld_byte_off_i), .ld_data_i(ld_data_i),
      .rd_addr_o(rd_addr_o), .rd_write_en_o(rd_write_en_o), .rd_data_o(rd_data_o),
      .retire_o(retire_o), .ld_err_o(ld_err_o), .busy_o(busy_o)
`ifdef WB_FWD_EN
      , .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o)
`endif
   );

   // clock
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Push one load, then check the write it produces one edge later.
   task automatic load_chk(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [31:0] w,
                           input logic [31:0] exp, input logic err);
      ld_valid_i = 1'b1; ld_rd_addr_i = rd; ld_funct3_i = f3;
      ld_byte_off_i = off; ld_data_i = w;
      tick();
      ld_valid_i = 1'b0;
      chk({tag, "_busy"}, W'(busy_o), W'(1));
      tick();
      chk({tag, "_we"},   W'(rd_write_en_o), W'(1));
      chk({tag, "_addr"}, W'(rd_addr_o), W'(rd));
      chk({tag, "_data"}, W'(rd_data_o), W'(exp));
      chk({tag, "_err"},  W'(ld_err_o), W'(err));
      chk({tag, "_ret"},  W'(retire_o), W'(1));
   endtask

   logic [4:0]  a_rd [3];
   logic [31:0] a_dt [3];
   logic [4:0]  l_rd [3];
   logic [31:0] l_dt [3];
   int ai, li, retires;
   logic alu_go, ld_go;

   initial begin
      // reset
      #1 reset_i = 1'b1;
      #1;
      chk("rst_we",     W'(rd_write_en_o), W'(0));
      chk("rst_retire", W'(retire_o), W'(0));
      chk("rst_err",    W'(ld_err_o), W'(0));
      chk("rst_busy",   W'(busy_o), W'(0));
      chk("rst_addr",   W'(rd_addr_o), W'(0));
      chk("rst_data",   W'(rd_data_o), W'(0));
      chk("rst_aready", W'(alu_ready_o), W'(0));
      chk("rst_lready", W'(ld_ready_o), W'(0));
      tick();
      reset_i = 1'b0;
      tick();
      chk("rel_we",     W'(rd_write_en_o), W'(0));
      chk("rel_aready", W'(alu_ready_o), W'(1));

      // ALU write x5
      alu_valid_i = 1'b1; alu_rd_addr_i = 5'd5; alu_data_i = 32'h1234_5678;
      tick();
      alu_valid_i = 1'b0;
      chk("alu_we",     W'(rd_write_en_o), W'(1));
      chk("alu_addr",   W'(rd_addr_o), W'(5));
      chk("alu_data",   W'(rd_data_o), W'(32'h1234_5678));
      chk("alu_retire", W'(retire_o), W'(1));
      tick();
      chk("alu_idle_we",  W'(rd_write_en_o), W'(0));
      chk("alu_idle_ret", W'(retire_o), W'(0));

      // load extension on word 0x80FF_7F01
      load_chk("lb1",  5'd1, 3'b000, 2'd1, 32'h80FF_7F01, 32'h0000_007F, 1'b0);
      load_chk("lb3",  5'd2, 3'b000, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b0);
      load_chk("lhu2", 5'd3, 3'b101, 2'd2, 32'h80FF_7F01, 32'h0000_80FF, 1'b0);
      load_chk("lh3",  5'd4, 3'b001, 2'd3, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0);
      load_chk("lw",   5'd6, 3'b010, 2'd1, 32'h80FF_7F01, 32'h80FF_7F01, 1'b0);
      load_chk("lbu3", 5'd8, 3'b100, 2'd3, 32'h80FF_7F01, 32'h0000_0080, 1'b0);
      load_chk("lh0",  5'd9, 3'b001, 2'd1, 32'h80FF_7F01, 32'h0000_7F01, 1'b0);
      load_chk("ill",  5'd7, 3'b011, 2'd0, 32'h80FF_7F01, 32'h0000_0000, 1'b1);
      tick();
      chk("ill_err_pulse", W'(ld_err_o), W'(0));
      chk("ld_idle_busy",  W'(busy_o), W'(0));

      // ALU to x0: retire without write
      alu_valid_i = 1'b1; alu_rd_addr_i = 5'd0; alu_data_i = 32'hFFFF_FFFF;
      tick();
      alu_valid_i = 1'b0;
      chk("x0_we",     W'(rd_write_en_o), W'(0));
      chk("x0_addr",   W'(rd_addr_o), W'(0));
      chk("x0_data",   W'(rd_data_o), W'(0));
      chk("x0_retire", W'(retire_o), W'(1));

`ifdef WB_FWD_EN
      alu_valid_i = 1'b1; alu_rd_addr_i = 5'd9; alu_data_i = 32'hDEAD_BEEF;
      tick();
      alu_valid_i = 1'b0;
      chk("fwd_valid", W'(fwd_valid_o), W'(1));
      chk("fwd_addr",  W'(fwd_addr_o), W'(9));
      chk("fwd_data",  W'(fwd_data_o), W'(32'hDEAD_BEEF));
      tick();
      chk("fwd_hold",  W'(fwd_data_o), W'(32'hDEAD_BEEF));
`endif

      // arbitration: continuous ALU plus three loads; expected commit order by hand
      a_rd[0] = 5'd10; a_dt[0] = 32'hA000_0000;
      a_rd[1] = 5'd11; a_dt[1] = 32'hA000_0001;
      a_rd[2] = 5'd12; a_dt[2] = 32'hA000_0002;
      l_rd[0] = 5'd20; l_dt[0] = 32'hB000_0000;
      l_rd[1] = 5'd21; l_dt[1] = 32'hB000_0001;
      l_rd[2] = 5'd22; l_dt[2] = 32'hB000_0002;
      exp_q.push_back({a_rd[0], a_dt[0]});
      exp_q.push_back({a_rd[1], a_dt[1]});
      exp_q.push_back({l_rd[0], l_dt[0]});
      exp_q.push_back({a_rd[2], a_dt[2]});
      exp_q.push_back({l_rd[1], l_dt[1]});
      exp_q.push_back({l_rd[2], l_dt[2]});
      ai = 0; li = 0; retires = 0;
      ld_funct3_i = 3'b010; ld_byte_off_i = 2'd0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         alu_valid_i = (ai < 3);
         if (ai < 3) begin alu_rd_addr_i = a_rd[ai]; alu_data_i = a_dt[ai]; end
         ld_valid_i = (li < 3);
         if (li < 3) begin ld_rd_addr_i = l_rd[li]; ld_data_i = l_dt[li]; end
         #1;
         alu_go = alu_valid_i && alu_ready_o;
         ld_go  = ld_valid_i && ld_ready_o;
         tick();
         if (alu_go) ai++;
         if (ld_go) li++;
         if (retire_o) retires++;
         if (cyc == 1) begin
            chk("arb_full_lready", W'(ld_ready_o), W'(0));
            chk("arb_full_aready", W'(alu_ready_o), W'(0));
            chk("arb_full_busy",   W'(busy_o), W'(1));
         end
         if (cyc == 2) chk("arb_pop_addr", W'(rd_addr_o), W'(20));
         if (rd_write_en_o) begin
            if (exp_q.size() == 0) chk("arb_extra_write", W'({rd_addr_o, rd_data_o}), W'(0));
            else chk("arb_write", {rd_addr_o, rd_data_o}, exp_q.pop_front());
         end
      end
      alu_valid_i = 1'b0; ld_valid_i = 1'b0;
      chk("arb_left",    W'(exp_q.size()), W'(0));
      chk("arb_retires", W'(retires), W'(6));
      chk("arb_busy",    W'(busy_o), W'(0));

      // reset mid-operation with two loads queued
      alu_valid_i = 1'b1; alu_rd_addr_i = 5'd3; alu_data_i = 32'h0000_0033;
      ld_valid_i = 1'b1; ld_rd_addr_i = 5'd4; ld_funct3_i = 3'b010; ld_data_i = 32'h0000_0044;
      tick();
      tick();
      alu_valid_i = 1'b0; ld_valid_i = 1'b0;
      chk("mid_busy",   W'(busy_o), W'(1));
      chk("mid_lready", W'(ld_ready_o), W'(0));
      chk("mid_we",     W'(rd_write_en_o), W'(1));
      #2 reset_i = 1'b1;
      #1;
      chk("mrst_we",     W'(rd_write_en_o), W'(0));
      chk("mrst_retire", W'(retire_o), W'(0));
      chk("mrst_addr",   W'(rd_addr_o), W'(0));
      chk("mrst_data",   W'(rd_data_o), W'(0));
      chk("mrst_busy",   W'(busy_o), W'(0));
      tick();
      reset_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("post_we",     W'(rd_write_en_o), W'(0));
         chk("post_retire", W'(retire_o), W'(0));
         chk("post_busy",   W'(busy_o), W'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global time limit
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the integer register file.
- Collects results from the ALU path and the load path, each with a valid/ready handshake.
- Buffers load returns in a small FIFO and sign/zero-extends load data.
- Arbitrates between the two sources and drives the register file write port (rd_addr/rd_write_en/rd_data) one write per cycle.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.
- LQ_DEPTH, 2, load-return FIFO entries; power of 2, minimum 2.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous active-high reset
- alu_valid_i  in  1  ALU result valid
- alu_ready_o  out  1  ALU result accepted this cycle
- alu_rd_addr_i  in  REG_ADDR_W  ALU destination register
- alu_data_i  in  XLEN  ALU result
- ld_valid_i  in  1  load return valid
- ld_ready_o  out  1  load FIFO can accept
- ld_rd_addr_i  in  REG_ADDR_W  load destination register
- ld_funct3_i  in  3  load type (RV32I funct3)
- ld_byte_off_i  in  2  address bits [1:0]
- ld_data_i  in  XLEN  raw aligned memory word
- rd_addr_o  out  REG_ADDR_W  register file write address
- rd_write_en_o  out  1  register file write enable
- rd_data_o  out  XLEN  register file write data
- retire_o  out  1  one-cycle pulse per committed result, including rd=x0
- ld_err_o  out  1  one-cycle pulse on illegal load funct3
- busy_o  out  1  load FIFO non-empty
- fwd_valid_o / fwd_addr_o / fwd_data_o  out  1 / REG_ADDR_W / XLEN  present only with WB_FWD_EN

Behaviour:
- Reset: asynchronous, active-high, clears state immediately.
  - All outputs read 0; FIFO pointers and count cleared.
  - Reset asserted mid-operation discards FIFO contents; no write is issued on the first edge after release.
- Handshake:
  - A transfer occurs on a rising edge with valid=1 and ready=1.
  - Sources must hold addr/data stable while valid=1 and ready=0.
- ld_ready_o = !lq_full. There is no same-cycle pass-through when full, even if a pop occurs that cycle.
- Arbitration, evaluated each cycle:
  - If lq_full: pop load FIFO, alu_ready_o=0.
  - Else if alu_valid_i: accept ALU (alu_ready_o=1); FIFO does not pop.
  - Else if FIFO non-empty: pop load.
  - Else: no write.
  - alu_ready_o = !lq_full (combinational).
- Outputs are registered; latency is 1 cycle from acceptance/pop edge to rd_write_en_o.
  - Minimum load latency: 1 cycle to enter the FIFO plus 1 cycle to write.
- Same-cycle push and pop on a non-full FIFO is allowed; count stays unchanged. Pointers wrap modulo LQ_DEPTH.
- Load extension is applied at pop time. Lane = ld_byte_off_i.
  - 000 LB: sign-extend byte at lane.
  - 100 LBU: zero-extend byte at lane.
  - 001 LH: sign-extend halfword at off[1]; off[0] ignored.
  - 101 LHU: zero-extend halfword at off[1]; off[0] ignored.
  - 010 LW: whole word; offset ignored.
  - 011/110/111: data = 0, write still performed, ld_err_o pulses in the same cycle as rd_write_en_o.
- Destination x0:
  - rd_write_en_o=0, rd_addr_o=0, rd_data_o=0; retire_o still pulses.
- rd_write_en_o and retire_o are high for exactly one cycle per committed result; back-to-back writes are allowed every cycle.

Optional Feature:
- WB_FWD_EN defined:
  - fwd_* ports are present.
  - On the cycle rd_write_en_o=1, fwd_valid_o=1 with fwd_addr_o/fwd_data_o equal to rd_addr_o/rd_data_o.
  - Registered copies are held until the next write; cleared to 0 on reset.
  - Purpose: covers the register-file read-after-write hazard.
- WB_FWD_EN not defined:
  - fwd_* ports and logic are absent; all other behaviour is identical.

Test Plan:
- ALU write: alu_valid_i=1, rd=5, data=0x1234_5678 -> next cycle rd_write_en_o=1, rd_addr_o=5, rd_data_o=0x1234_5678, retire_o=1.
- Load extension, word 0x80FF_7F01:
  - LB off=1 -> 0x0000_007F.
  - LB off=3 -> 0xFFFF_FF80.
  - LHU off=2 -> 0x0000_80FF.
  - LH off=3 -> 0xFFFF_80FF.
  - LW -> 0x80FF_7F01.
- Arbitration/full:
  - Continuous alu_valid_i plus 3 loads -> FIFO fills with 2, ld_ready_o=0.
  - Next cycle alu_ready_o=0 and a load writes.
  - ALU resumes after the pop; no result is lost or duplicated.
- x0 and illegal load:
  - ALU rd=0 -> rd_write_en_o=0, retire_o=1.
  - Load funct3=011, rd=7 -> write x7=0, ld_err_o=1.
- Reset mid-operation: FIFO holding 2 loads, assert reset_i between edges -> outputs 0 immediately; after release, busy_o=0 and no writes occur.
- WB_FWD_EN: write x9=0xDEAD_BEEF -> fwd_valid_o=1, fwd_addr_o=9, fwd_data_o=0xDEAD_BEEF in the same cycle as rd_write_en_o.
